instr_mem_responder: RTL and testbench

- Responder (slave) end of the L1 instruction-fetch request/response interface; the compute-unit pipeline is the initiator.
- Accepts word-addressed fetch requests, forwards them to an in-order instruction memory port, and returns data paired with the request tag.
- Holds returned data until the pipeline accepts it, using credit-limited outstanding tracking.
- Sits between the compute-unit pipeline and the instruction memory / L2 arbiter.

---
 rtl/e_gpu_icache_pkg.sv | 23 ++
 rtl/instr_rsp_fifo.sv | 61 ++++++
 rtl/instr_mem_responder.sv | 139 +++++++++++++
 tb/tb_instr_mem_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_gpu_icache_pkg.sv
// ----------------------------------------------------------------------------
// e_gpu_icache_pkg
// Shared widths and types for the L1 instruction-fetch path.
//   ICACHE_ADDR_W : word address width (byte address bits [31:2])
//   ICACHE_DATA_W : instruction word width
//   ICACHE_TAG_W  : fetch tag width, echoed unchanged on the response
//   icache_tag_t  : fetch tag
//   icache_rsp_t  : tag/data pair as seen by the pipeline
// ----------------------------------------------------------------------------
package e_gpu_icache_pkg;

    localparam int ICACHE_ADDR_W = 30;
    localparam int ICACHE_DATA_W = 32;
    localparam int ICACHE_TAG_W  = 8;

    typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;

    typedef struct packed {
        icache_tag_t              tag;
        logic [ICACHE_DATA_W-1:0] data;
    } icache_rsp_t;

endpackage

// File: rtl/instr_rsp_fifo.sv
// ----------------------------------------------------------------------------
// instr_rsp_fifo
// Synchronous FIFO with a registered write and a combinational head.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, din_i : write request and data
//   pop_i         : remove the head entry (ignored when empty)
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//   head_o        : oldest entry, valid while !empty_o
// ----------------------------------------------------------------------------
module instr_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok, pop_ok;

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full FIFO is allowed only when the head leaves in the
    // same cycle: the slot being written is the one being read out.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = store[rd_ptr];

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) store[wr_ptr] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
            else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// ----------------------------------------------------------------------------
// instr_mem_responder
// Responder end of the L1 instruction-fetch interface. Requests pass straight
// through to an in-order memory port while credit is available; returned
// words are queued and paired by order with the tags of the requests.
// Optional feature macro: INSTR_MEM_RESPONDER_PERF_EN (adds perf counters).
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_valid_i/addr_i/tag_i : fetch request from the pipeline
//   req_ready_o              : request accepted (with req_valid_i)
//   rsp_valid_o/data_o/tag_o : response to the pipeline, held until ready
//   rsp_ready_i              : pipeline accepts response
//   mem_req_valid_o/addr_o   : memory read request
//   mem_req_ready_i          : memory accepts request
//   mem_rsp_valid_i/data_i   : in-order memory read data, no backpressure
//   busy_o                   : at least one request outstanding
//   perf_req_count_o         : request handshakes (PERF_EN only)
//   perf_stall_count_o       : cycles with a refused request (PERF_EN only)
// ----------------------------------------------------------------------------
module instr_mem_responder
    import e_gpu_icache_pkg::*;
#(
    parameter int ADDR_W          = ICACHE_ADDR_W,
    parameter int DATA_W          = ICACHE_DATA_W,
    parameter int TAG_W           = ICACHE_TAG_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    input  logic              rsp_ready_i,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output logic              busy_o
`ifdef INSTR_MEM_RESPONDER_PERF_EN
    ,
    output logic [31:0]       perf_req_count_o,
    output logic [31:0]       perf_stall_count_o
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] cnt;       // accepted, not yet popped by the pipeline
    logic [CNT_W-1:0] inflight;  // sent to memory, data not yet returned
    logic             credit_ok, req_hs, rsp_hs, data_push;
    logic             tag_full, tag_empty, data_full, data_empty;

    assign credit_ok       = (cnt < CNT_W'(MAX_OUTSTANDING));
    assign req_ready_o     = mem_req_ready_i && credit_ok;
    assign mem_req_valid_o = req_valid_i && credit_ok;
    assign mem_req_addr_o  = req_addr_i;
    assign req_hs          = req_valid_i && req_ready_o;
    assign rsp_valid_o     = !data_empty;
    assign rsp_hs          = rsp_valid_o && rsp_ready_i;
    assign busy_o          = (cnt != '0);
    // Data with nothing in flight (e.g. a late return across reset) is dropped.
    assign data_push       = mem_rsp_valid_i && (inflight != '0);

    // Credit only reopens through the registered count, so a pop at
    // cnt == MAX_OUTSTANDING admits a new request one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (req_hs && !rsp_hs) begin
            cnt <= cnt + CNT_W'(1);
        end else if (rsp_hs && !req_hs) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Memory cannot answer in the cycle of its own request, so the return
    // can never race the increment for the same entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= '0;
        end else if (req_hs && !data_push) begin
            inflight <= inflight + CNT_W'(1);
        end else if (data_push && !req_hs) begin
            inflight <= inflight - CNT_W'(1);
        end
    end

    instr_rsp_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_hs),
        .din_i   (req_tag_i),
        .pop_i   (rsp_hs),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .head_o  (rsp_tag_o)
    );

    instr_rsp_fifo #(.WIDTH(DATA_W), .DEPTH(MAX_OUTSTANDING)) u_data_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (data_push),
        .din_i   (mem_rsp_data_i),
        .pop_i   (rsp_hs),
        .full_o  (data_full),
        .empty_o (data_empty),
        .head_o  (rsp_data_o)
    );

`ifdef INSTR_MEM_RESPONDER_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_req_count_o   <= '0;
            perf_stall_count_o <= '0;
        end else begin
            if (req_hs)                     perf_req_count_o   <= perf_req_count_o + 32'd1;
            if (req_valid_i && !req_ready_o) perf_stall_count_o <= perf_stall_count_o + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rsp_valid_i |-> (inflight != '0))
        else $warning("instr_mem_responder: memory data with no request in flight dropped");
    a_tag_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_hs |-> (!tag_full || rsp_hs));
    a_data_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_push |-> (!data_full || rsp_hs));
    a_tag_paired: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_o |-> !tag_empty);
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_responder
// Scoreboard bench: every accepted request pushes its expected tag/data pair;
// every response handshake pops and compares. A small in-order memory model
// answers after a programmable latency. Per-cycle model checks cover credit,
// busy, response latency and head stability; directed sequences cover the
// single fetch, full-credit stall, toggling ready, pop-at-full, reset with
// outstanding requests and (when enabled) the perf counters.
// ----------------------------------------------------------------------------
module tb_instr_mem_responder;
    import e_gpu_icache_pkg::*;

    localparam int MAXO = 4;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [29:0] req_addr = '0;
    icache_tag_t req_tag = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    icache_tag_t rsp_tag;
    logic        rsp_ready = 1'b0;
    logic        mem_req_valid;
    logic [29:0] mem_req_addr;
    logic        mem_ready = 1'b1;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        busy;
    logic        mdl_vld = 1'b0;
    logic [31:0] mdl_data = '0;
    logic        stray = 1'b0;
`ifdef INSTR_MEM_RESPONDER_PERF_EN
    logic [31:0] perf_req, perf_stall;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    int          m_cnt = 0;
    int          p_req = 0;
    int          p_stall = 0;
    icache_rsp_t exp_q [$];
    mem_ent_t    mem_q [$];
    logic        prv_mvld = 1'b0, prv_rvld = 1'b0, prv_rrdy = 1'b0;
    logic [31:0] prv_data = '0;
    icache_tag_t prv_tag = '0;

    assign mem_rsp_valid = mdl_vld | stray;
    assign mem_rsp_data  = stray ? 32'hBAD0_BAD0 : mdl_data;

    instr_mem_responder #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_addr_i      (req_addr),
        .req_tag_i       (req_tag),
        .req_ready_o     (req_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .rsp_tag_o       (rsp_tag),
        .rsp_ready_i     (rsp_ready),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_ready_i (mem_ready),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .busy_o          (busy)
`ifdef INSTR_MEM_RESPONDER_PERF_EN
        ,
        .perf_req_count_o   (perf_req),
        .perf_stall_count_o (perf_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tg, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tg, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic cyc_drv();
        @(posedge clk);
        #1;
    endtask

    // In-order memory: one word per cycle once its latency has elapsed.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_q.delete();
            mdl_vld = 1'b0;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            mdl_vld  = 1'b1;
            mdl_data = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            mdl_vld = 1'b0;
        end
    end

    // Monitor + scoreboard. Inputs change just after posedge, so the values
    // seen here are the ones the DUT samples at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; p_req = 0; p_stall = 0;
            exp_q.delete(); mem_q.delete();
            prv_mvld = 1'b0; prv_rvld = 1'b0; prv_rrdy = 1'b0;
        end else begin
            chk("busy", busy, m_cnt != 0);
            chk("req_ready", req_ready, mem_ready && (m_cnt < MAXO));
            chk("mem_req_valid", mem_req_valid, req_valid && (m_cnt < MAXO));
            if (req_valid) chk("mem_req_addr", mem_req_addr, req_addr);
`ifdef INSTR_MEM_RESPONDER_PERF_EN
            chk("perf_req", perf_req, p_req);
            chk("perf_stall", perf_stall, p_stall);
`endif
            if (prv_mvld) chk("rsp_latency", rsp_valid, 1'b1);
            if (prv_rvld && !prv_rrdy) begin
                chk("hold_valid", rsp_valid, 1'b1);
                chk("hold_data", rsp_data, prv_data);
                chk("hold_tag", rsp_tag, prv_tag);
            end
            if (req_valid && req_ready) begin
                exp_q.push_back('{tag: req_tag, data: mem_word(req_addr)});
                mem_q.push_back('{due: cyc + lat, data: mem_word(req_addr)});
                m_cnt++;
                p_req++;
            end
            if (req_valid && !req_ready) p_stall++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    chk("sb_tag", rsp_tag, exp_q[0].tag);
                    chk("sb_data", rsp_data, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                m_cnt--;
            end
            prv_mvld = mdl_vld;
            prv_rvld = rsp_valid;
            prv_rrdy = rsp_ready;
            prv_data = rsp_data;
            prv_tag  = rsp_tag;
        end
    end

    task automatic wait_idle(input string tg);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 40) begin
            cyc_drv();
            n++;
        end
        chk(tg, busy, 1'b0);
    endtask

    initial begin
        int acc;
        int n;
        logic [7:0] pat;

        // reset state
        #2;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) cyc_drv();
        rst_n = 1'b1;

        // single fetch, memory latency 2
        lat = 2;
        cyc_drv();
        req_valid = 1'b1; req_addr = 30'h100; req_tag = 8'h03;
        @(negedge clk);
        chk("t1_req_ready", req_ready, 1'b1);
        chk("t1_mem_addr", mem_req_addr, 30'h100);
        cyc_drv();
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mdl_vld && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t1_mem_rsp_seen", mdl_vld, 1'b1);
        chk("t1_no_bypass", rsp_valid, 1'b0);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);
        chk("t1_rsp_tag", rsp_tag, 8'h03);
        cyc_drv();
        rsp_ready = 1'b1;
        @(negedge clk);
        cyc_drv();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t1_busy_drop", busy, 1'b0);
        chk("t1_rsp_gone", rsp_valid, 1'b0);

        // 6 back-to-back requests against 4 credits, then drain
        lat = 1;
        acc = 0;
        repeat (8) begin
            cyc_drv();
            req_valid = 1'b1; req_addr = 30'h300 + 30'(acc); req_tag = 8'h20 + 8'(acc);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
        end
        chk("t2_accepted", acc, 4);
        chk("t2_ready_low", req_ready, 1'b0);
        chk("t2_memvalid_low", mem_req_valid, 1'b0);
        cyc_drv();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t2_pop_no_credit", req_ready, 1'b0);
        chk("t2_pop_valid", rsp_valid, 1'b1);
        cyc_drv();
        @(negedge clk);
        chk("t2_credit_back", req_ready, 1'b1);
        if (req_valid && req_ready) acc++;
        n = 0;
        while (acc < 6 && n < 20) begin
            cyc_drv();
            req_addr = 30'h300 + 30'(acc); req_tag = 8'h20 + 8'(acc);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            n++;
        end
        chk("t2_all_accepted", acc, 6);
        cyc_drv();
        req_valid = 1'b0;
        wait_idle("t2_drained");
        rsp_ready = 1'b0;

        // tags 0x10..0x13 with rsp_ready toggling every cycle
        acc = 0; n = 0;
        while ((acc < 4 || busy) && n < 40) begin
            cyc_drv();
            rsp_ready = ~rsp_ready;
            req_valid = (acc < 4);
            req_addr  = 30'h200 + 30'(acc);
            req_tag   = 8'h10 + 8'(acc);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            n++;
        end
        chk("t3_accepted", acc, 4);
        cyc_drv();
        req_valid = 1'b0; rsp_ready = 1'b0;
        wait_idle("t3_drained");

        // pop at full credit together with a new request
        acc = 0; n = 0;
        while (acc < 4 && n < 10) begin
            cyc_drv();
            req_valid = 1'b1; req_addr = 30'h500 + 30'(acc); req_tag = 8'h50 + 8'(acc);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            n++;
        end
        cyc_drv();
        req_valid = 1'b0;
        repeat (3) cyc_drv();
        chk("t4_head_ready", rsp_valid, 1'b1);
        req_valid = 1'b1; req_addr = 30'h504; req_tag = 8'h54; rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_no_accept_at_pop", req_ready, 1'b0);
        cyc_drv();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t4_accept_next", req_ready, 1'b1);
        cyc_drv();
        req_valid = 1'b0;
        @(negedge clk);
        chk("t4_full_again", req_ready, 1'b0);
        chk("t4_busy", busy, 1'b1);
        cyc_drv();
        rsp_ready = 1'b1;
        wait_idle("t4_drained");
        rsp_ready = 1'b0;

        // reset with 3 outstanding, then a stray memory return
        acc = 0; n = 0;
        while (acc < 3 && n < 10) begin
            cyc_drv();
            req_valid = 1'b1; req_addr = 30'h600 + 30'(acc); req_tag = 8'h60 + 8'(acc);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            n++;
        end
        cyc_drv();
        req_valid = 1'b0;
        repeat (2) cyc_drv();
        chk("t5_pre_valid", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", rsp_valid, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        repeat (2) cyc_drv();
        rst_n = 1'b1;
        cyc_drv();
        stray = 1'b1;
        @(negedge clk);
        chk("t5_stray_now", rsp_valid, 1'b0);
        cyc_drv();
        stray = 1'b0;
        @(negedge clk);
        chk("t5_stray_dropped", rsp_valid, 1'b0);
        chk("t5_stray_busy", busy, 1'b0);

`ifdef INSTR_MEM_RESPONDER_PERF_EN
        // 5 accepted requests with 3 memory-stall cycles
        rsp_ready = 1'b1;
        pat = 8'b1110_1001;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_drv();
            mem_ready = pat[i];
            req_valid = 1'b1; req_addr = 30'h700 + 30'(acc); req_tag = 8'h70 + 8'(acc);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
        end
        cyc_drv();
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("t6_perf_req", perf_req, 32'd5);
        chk("t6_perf_stall", perf_stall, 32'd3);
        wait_idle("t6_drained");
        rsp_ready = 1'b0;
`else
        pat = 8'h00;
`endif

        cyc_drv();
        chk("final_sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
